branch_target_buffer: RTL

- Parametrised direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Sits in the IF stage beside the PC adder. It predicts the next PC for the fetch address every cycle, so fewer taken branches and jumps need an IF/ID flush.
- Trained from the ID stage once a branch or jump resolves.
- Provides a multi-cycle invalidate-all sequence for context switches and self-modifying code.

---
 rtl/branch_target_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with saturating direction counters
// Combinational lookup from registered entries; ID-stage training; multi-cycle invalidate-all.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              clear_i,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [ENTRIES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_en, up_hit;
  logic             unused_pc_lsbs;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^upd_pc_i[1:0];

  assign busy_o = (state_q == S_CLEAR);
  assign up_en  = upd_valid_i & ~busy_o;
  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

  assign hit_o         = ~busy_o & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = hit_o & cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE: begin
        if (up_en && upd_taken_i) valid_d[up_idx] = 1'b1;
        if (clear_i) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        // clear_i is ignored here so an in-flight sweep is never restarted
        valid_d[clr_idx_q] = 1'b0;
        clr_idx_d          = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(ENTRIES - 1)) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      clr_idx_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      valid_q   <= valid_d;
    end
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (up_en && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
      if (!up_hit)
        cnt_q[up_idx] <= CNT_WT;
      else if (cnt_q[up_idx] != CNT_MAX)
        cnt_q[up_idx] <= cnt_q[up_idx] + 1'b1;
    end else if (up_en && up_hit && (cnt_q[up_idx] != '0)) begin
      cnt_q[up_idx] <= cnt_q[up_idx] - 1'b1;
    end
  end

endmodule
